dcache_wt: RTL

Parametrised, direct-mapped, write-through, no-write-allocate data cache that sits between the MIPS core's load/store port and a word-wide backing memory. It replaces the fixed single-cycle data store with a configurable geometry, a miss-fill state machine with line bursts, a ready/valid core handshake, and hit/miss counters.

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_wt_if.sv | 31 +++
 rtl/dcache_line_ram.sv | 59 +++++
 rtl/dcache_wt.sv | 132 +++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  function automatic int word_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int offset_w(input int words);
    return $clog2(words) + 2;
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int lines, input int words);
    return addr_w - offset_w(words) - index_w(lines);
  endfunction

endpackage

// File: rtl/dcache_wt_if.sv
// Core load/store handshake plus word-wide backing-memory bus seen by the cache.
interface dcache_wt_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_rd_en;
  logic              core_wr_en;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_ready;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // Cache side
  modport slave (
    input  core_rd_en, core_wr_en, core_addr, core_wdata, mem_ack, mem_rdata,
    output core_ready, core_rvalid, core_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  // Core + memory side
  modport master (
    output core_rd_en, core_wr_en, core_addr, core_wdata, mem_ack, mem_rdata,
    input  core_ready, core_rvalid, core_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_line_ram.sv
// Line storage: data array with registered read, plus per-line tag and valid bit.
module dcache_line_ram #(
  parameter int LINES   = 16,
  parameter int WORDS   = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 24,
  parameter int INDEX_W = $clog2(LINES),
  parameter int WORD_W  = $clog2(WORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] rd_line,
  input  logic [WORD_W-1:0]  rd_word,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_line,
  input  logic [WORD_W-1:0]  wr_word,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               tag_we,
  input  logic [INDEX_W-1:0] tag_line,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic [INDEX_W-1:0] lk_line,
  output logic               lk_valid,
  output logic [TAG_W-1:0]   lk_tag
);
  localparam int DEPTH = LINES * WORDS;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem [LINES];
  logic [LINES-1:0]  valid_reg;
  logic [LINES-1:0]  valid_set;

  always_ff @(posedge clk) begin
    if (wr_en) data_mem[{wr_line, wr_word}] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else if (rd_en) rd_data <= data_mem[{rd_line, rd_word}];
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[tag_line] <= tag_in;
  end

  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    assign valid_set[gi] = tag_we && (tag_line == INDEX_W'(gi));
  end

  // A line only becomes valid once its whole fill has landed; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_reg <= '0;
    else     valid_reg <= valid_reg | valid_set;
  end

  assign lk_valid = valid_reg[lk_line];
  assign lk_tag   = tag_mem[lk_line];
endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with line-burst miss fill.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  dcache_wt_if.slave  bus,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int WORD_W   = word_w(WORDS);
  localparam int OFFSET_W = offset_w(WORDS);
  localparam int INDEX_W  = index_w(LINES);
  localparam int TAG_W    = tag_w(ADDR_W, LINES, WORDS);

  state_t state_reg, state_next;

  logic [ADDR_W-3:0] req_addr_reg;
  logic [WORD_W-1:0] word_cnt_reg;
  logic [DATA_W-1:0] fill_word_reg;
  logic              hit_rvalid_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  logic [WORD_W-1:0]  req_word, cap_word;
  logic [INDEX_W-1:0] req_index, cap_index;
  logic [TAG_W-1:0]   req_tag, cap_tag, lk_tag;
  logic [DATA_W-1:0]  ram_rdata;
  logic               lk_valid, hit, accept, acc_wr, acc_rd, fill_ack, last_ack;

  assign req_word  = bus.core_addr[2 +: WORD_W];
  assign req_index = bus.core_addr[OFFSET_W +: INDEX_W];
  assign req_tag   = bus.core_addr[ADDR_W-1 -: TAG_W];
  assign cap_word  = req_addr_reg[0 +: WORD_W];
  assign cap_index = req_addr_reg[WORD_W +: INDEX_W];
  assign cap_tag   = req_addr_reg[ADDR_W-3 -: TAG_W];

  assign hit      = lk_valid && (lk_tag == req_tag);
  assign accept   = (state_reg == IDLE) && (bus.core_rd_en || bus.core_wr_en);
  assign acc_wr   = accept && bus.core_wr_en;
  assign acc_rd   = accept && !bus.core_wr_en;
  assign fill_ack = (state_reg == FILL) && bus.mem_ack;
  assign last_ack = fill_ack && (word_cnt_reg == WORD_W'(WORDS - 1));

  // Single write port shared by fill words and store hits; they never coincide.
  dcache_line_ram #(
    .LINES(LINES), .WORDS(WORDS), .DATA_W(DATA_W), .TAG_W(TAG_W),
    .INDEX_W(INDEX_W), .WORD_W(WORD_W)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (acc_rd && hit),
    .rd_line  (req_index),
    .rd_word  (req_word),
    .rd_data  (ram_rdata),
    .wr_en    (fill_ack || (acc_wr && hit)),
    .wr_line  (fill_ack ? cap_index : req_index),
    .wr_word  (fill_ack ? word_cnt_reg : req_word),
    .wr_data  (fill_ack ? bus.mem_rdata : bus.core_wdata),
    .tag_we   (last_ack),
    .tag_line (cap_index),
    .tag_in   (cap_tag),
    .lk_line  (req_index),
    .lk_valid (lk_valid),
    .lk_tag   (lk_tag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next      = state_reg;
    bus.core_ready  = (state_reg == IDLE);
    bus.core_rvalid = hit_rvalid_reg || (state_reg == RESP);
    bus.core_rdata  = (state_reg == RESP) ? fill_word_reg : ram_rdata;
    bus.mem_req     = (state_reg == FILL) || (state_reg == WRITE);
    bus.mem_we      = (state_reg == WRITE);
    bus.mem_addr    = mem_addr_reg;
    bus.mem_wdata   = mem_wdata_reg;
    case (state_reg)
      IDLE:    if (acc_wr) state_next = WRITE;
               else if (acc_rd && !hit) state_next = FILL;
      FILL:    if (last_ack) state_next = RESP;
      WRITE:   if (bus.mem_ack) state_next = IDLE;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr_reg   <= '0;
      word_cnt_reg   <= '0;
      fill_word_reg  <= '0;
      hit_rvalid_reg <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      hit_cnt        <= '0;
      miss_cnt       <= '0;
    end else begin
      hit_rvalid_reg <= acc_rd && hit;
      if (accept) begin
        req_addr_reg <= bus.core_addr[ADDR_W-1:2];
        word_cnt_reg <= '0;
        if (bus.core_wr_en) begin
          mem_addr_reg  <= {bus.core_addr[ADDR_W-1:2], 2'b00};
          mem_wdata_reg <= bus.core_wdata;
        end else begin
          mem_addr_reg <= {bus.core_addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
        end
        if (hit) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        end
      end
      // Requested word is captured as it streams past so RESP needs no RAM read.
      if (fill_ack) begin
        word_cnt_reg <= word_cnt_reg + WORD_W'(1);
        mem_addr_reg <= mem_addr_reg + ADDR_W'(4);
        if (word_cnt_reg == cap_word) fill_word_reg <= bus.mem_rdata;
      end
    end
  end
endmodule
